// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and constants for the SAR ADC sequencer
package sar_pkg;
   typedef enum logic [1:0] {IDLE, SAMPLE, STEP} state_t;
   localparam int SYNC_STAGES = 2;
   localparam int AVG_LOG2 = 2;
endpackage

// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if: start/comparator inputs and DAC/result outputs of the SAR sequencer
interface sar_adc_ctrl_if #(parameter int WIDTH = 8);
   logic start;
   logic comp_in;
   logic sample_en;
   logic busy;
   logic done;
   logic [WIDTH-1:0] dac_code;
   logic [WIDTH-1:0] result;
   modport master(output start, comp_in, input dac_code, sample_en, busy, done, result);
   modport slave(input start, comp_in, output dac_code, sample_en, busy, done, result);
endinterface

// File: rtl/sar_sync.sv
// sar_sync: multi-flop synchronizer for the asynchronous comparator output
module sar_sync #(parameter int STAGES = 2) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[STAGES-2:0], d};
   always_ff @(posedge clk) sync_q <= rst ? '0 : sync_d;
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation sequencer driving DAC code and track/hold
// SAR_AVG_EN: when defined, each start averages four back-to-back conversions
module sar_adc_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SETTLE = 3
) (
   input logic clk,
   input logic rst,
   sar_adc_ctrl_if.slave bus
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(SETTLE + 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] bit_q, bit_d;
   logic [WIDTH-1:0] dac_q, dac_d, res_q, res_d, trial, kept;
   logic sample_q, sample_d, busy_q, busy_d, done_q, done_d, comp_sync, last;
`ifdef SAR_AVG_EN
   logic [AVG_LOG2-1:0] conv_q, conv_d;
   logic [WIDTH+AVG_LOG2-1:0] sum_q, sum_d, sum_n;
`endif
   sar_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(bus.comp_in), .q(comp_sync));
   // dac_q doubles as the accumulator of decided bits plus the current trial bit
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      bit_d = bit_q;
      dac_d = dac_q;
      res_d = res_q;
      sample_d = sample_q;
      busy_d = busy_q;
      done_d = 1'b0;
      trial = WIDTH'(1) << bit_q;
      kept = comp_sync ? dac_q : dac_q & ~trial;
      last = cnt_q == CW'(SETTLE);
`ifdef SAR_AVG_EN
      conv_d = conv_q;
      sum_d = sum_q;
      sum_n = sum_q + (WIDTH+AVG_LOG2)'(kept);
`endif
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = SAMPLE;
            cnt_d = '0;
            sample_d = 1'b1;
            busy_d = 1'b1;
            dac_d = '0;
`ifdef SAR_AVG_EN
            conv_d = '0;
            sum_d = '0;
`endif
         end
         SAMPLE: begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last) begin
               state_d = STEP;
               bit_d = IW'(WIDTH - 1);
               sample_d = 1'b0;
               dac_d = {1'b1, {(WIDTH-1){1'b0}}};
            end
         end
         STEP: begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last && bit_q != '0) begin
               bit_d = bit_q - 1'b1;
               dac_d = kept | (trial >> 1);
            end else if (last) begin
               dac_d = kept;
               state_d = IDLE;
               busy_d = 1'b0;
               done_d = 1'b1;
`ifdef SAR_AVG_EN
               res_d = WIDTH'(sum_n >> AVG_LOG2);
               if (conv_q != '1) begin
                  conv_d = conv_q + 1'b1;
                  sum_d = sum_n;
                  state_d = SAMPLE;
                  sample_d = 1'b1;
                  busy_d = 1'b1;
                  done_d = 1'b0;
                  dac_d = '0;
                  res_d = res_q;
               end
`else
               res_d = kept;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         dac_q <= '0;
         res_q <= '0;
         sample_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         dac_q <= dac_d;
         res_q <= res_d;
         sample_q <= sample_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
`ifdef SAR_AVG_EN
   always_ff @(posedge clk) begin
      conv_q <= rst ? '0 : conv_d;
      sum_q <= rst ? '0 : sum_d;
   end
`endif
   assign bus.dac_code = dac_q;
   assign bus.sample_en = sample_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.result = res_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed bench for the SAR sequencer with an ideal comparator model
module tb_sar_adc_ctrl;
   import sar_pkg::*;
`ifdef SAR_AVG_EN
   localparam int LAT = 4 * 36;
`else
   localparam int LAT = 36;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] vin = 8'h00;
   logic [1:0] cmode = 2'd0;
   int n_cmp = 0;
   int n_bad = 0;
   sar_adc_ctrl_if #(.WIDTH(8)) bus ();
   sar_adc_ctrl #(.WIDTH(8), .SETTLE(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   always_comb bus.comp_in = (cmode == 2'd1) ? 1'b1 : (cmode == 2'd2) ? 1'b0 : (vin >= bus.dac_code);

   task automatic test_reset();
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.dac_code !== 8'h00) begin n_bad++; $display("FAIL reset_dac got %h want 00", bus.dac_code); end
      n_cmp++; if (bus.sample_en !== 1'b0) begin n_bad++; $display("FAIL reset_sample got %b want 0", bus.sample_en); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", bus.result); end
      n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_conv(input logic [7:0] v, input logic [1:0] mode, input logic [7:0] exp_res, input string name);
      int dones, done_at, busy_cnt;
      logic [7:0] res_at_done;
      vin = v;
      cmode = mode;
      dones = 0; done_at = 0; busy_cnt = 0; res_at_done = 8'hxx;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      for (int c = 1; c <= LAT + 8; c++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin dones++; done_at = c; res_at_done = bus.result; end
         @(negedge clk);
      end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL %s_done_count got %0d want 1", name, dones); end
      n_cmp++; if (done_at !== LAT + 1) begin n_bad++; $display("FAIL %s_done_cycle got %0d want %0d", name, done_at, LAT + 1); end
      n_cmp++; if (busy_cnt !== LAT) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cnt, LAT); end
      n_cmp++; if (res_at_done !== exp_res) begin n_bad++; $display("FAIL %s_result got %h want %h", name, res_at_done, exp_res); end
      n_cmp++; if (bus.dac_code !== exp_res) begin n_bad++; $display("FAIL %s_dac_hold got %h want %h", name, bus.dac_code, exp_res); end
      cmode = 2'd0;
   endtask

   task automatic test_trials();
      logic [7:0] tr [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      vin = 8'hA5;
      cmode = 2'd0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      n_cmp++; if (bus.sample_en !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL trials_sample got sample=%b busy=%b want 1/1", bus.sample_en, bus.busy); end
      for (int c = 1; c <= LAT + 4; c++) begin
         if (c >= 5 && (c - 5) % 4 == 0 && (c - 5) / 4 < 8) begin
            n_cmp++; if (bus.dac_code !== tr[(c-5)/4]) begin n_bad++; $display("FAIL trial_%0d got %h want %h", (c-5)/4, bus.dac_code, tr[(c-5)/4]); end
         end
         if (c == 5) begin
            n_cmp++; if (bus.sample_en !== 1'b0) begin n_bad++; $display("FAIL trials_sample_off got %b want 0", bus.sample_en); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_start_held();
      int dones, d1, d2, idle_bad;
      vin = 8'h5A;
      dones = 0; d1 = 0; d2 = 0; idle_bad = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 2 * LAT + 2; c++) begin
         if (bus.done === 1'b1) begin dones++; if (d1 == 0) d1 = c; else d2 = c; end
         if (bus.busy !== 1'b1 && bus.done !== 1'b1) idle_bad++;
         if (bus.busy === 1'b1 && bus.done === 1'b1) idle_bad++;
         if (c == 2 * LAT + 2) bus.start = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL held_done_count got %0d want 2", dones); end
      n_cmp++; if (d1 !== LAT + 1) begin n_bad++; $display("FAIL held_first_done got %0d want %0d", d1, LAT + 1); end
      n_cmp++; if (d2 !== 2 * LAT + 2) begin n_bad++; $display("FAIL held_second_done got %0d want %0d", d2, 2 * LAT + 2); end
      n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL held_busy_gap got %0d bad cycles want 0", idle_bad); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL held_stop got busy=%b want 0", bus.busy); end
      n_cmp++; if (bus.result !== 8'h5A) begin n_bad++; $display("FAIL held_result got %h want 5a", bus.result); end
   endtask

   task automatic test_start_mid();
      int dones, busy_after;
      vin = 8'h33;
      dones = 0; busy_after = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      for (int c = 1; c <= LAT + 10; c++) begin
         bus.start = (c == 10 || c == 20);
         if (bus.done === 1'b1) dones++;
         if (c > LAT + 1 && bus.busy === 1'b1) busy_after++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL mid_start_done_count got %0d want 1", dones); end
      n_cmp++; if (busy_after !== 0) begin n_bad++; $display("FAIL mid_start_requeued got %0d busy cycles want 0", busy_after); end
      n_cmp++; if (bus.result !== 8'h33) begin n_bad++; $display("FAIL mid_start_result got %h want 33", bus.result); end
   endtask

   task automatic test_reset_mid();
      int dones;
      vin = 8'h77;
      dones = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      for (int c = 1; c < 10; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({bus.dac_code, bus.result} !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_codes got %h/%h want 00/00", bus.dac_code, bus.result); end
      n_cmp++; if ({bus.busy, bus.sample_en, bus.done} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_flags got %b want 000", {bus.busy, bus.sample_en, bus.done}); end
      n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rst_mid_state got %0d want IDLE", dut.state_q); end
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
         @(negedge clk);
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_mid_activity got %0d want 0", dones); end
      run_conv(8'h3C, 2'd0, 8'h3C, "after_rst");
   endtask

`ifdef SAR_AVG_EN
   task automatic test_avg();
      int dones, done_at;
      logic [7:0] res_at_done;
      dones = 0; done_at = 0; res_at_done = 8'hxx;
      vin = 8'h40;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      for (int c = 1; c <= 160; c++) begin
         if (c <= 144 && (c - 1) % 36 == 0) vin = ((c - 1) / 36) % 2 ? 8'h43 : 8'h40;
         if (bus.done === 1'b1) begin dones++; done_at = c; res_at_done = bus.result; end
         @(negedge clk);
      end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL avg_done_count got %0d want 1", dones); end
      n_cmp++; if (done_at !== 145) begin n_bad++; $display("FAIL avg_done_cycle got %0d want 145", done_at); end
      n_cmp++; if (res_at_done !== 8'h41) begin n_bad++; $display("FAIL avg_result got %h want 41", res_at_done); end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      test_reset();
      test_trials();
      run_conv(8'hA5, 2'd0, 8'hA5, "a5");
      run_conv(8'h00, 2'd1, 8'hFF, "tie1");
      run_conv(8'h00, 2'd2, 8'h00, "tie0");
      test_start_held();
      test_start_mid();
      test_reset_mid();
`ifdef SAR_AVG_EN
      test_avg();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
